// File: rtl/rs_encode_stream_out_engine_pkg.sv
// Shared types and geometry helper for the Reed-Solomon encoder output stage.
// Keeps encoder and output engine agreeing on lines per block, slots per line and buffer depth.
package rs_encode_stream_out_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } rs_out_state_e;

    typedef struct packed {
        logic [31:0] lines_per_blk;
        logic [31:0] ppl;
        logic [31:0] par_depth;
    } rs_geom_t;

    function automatic rs_geom_t rs_geom(input int data_w, input int k_bytes,
                                         input int t_bytes, input int max_blocks);
        rs_geom_t g;
        int       ppl;
        ppl             = (data_w / 8) / t_bytes;
        g.lines_per_blk = 32'(k_bytes / (data_w / 8));
        g.ppl           = 32'(ppl);
        g.par_depth     = 32'((max_blocks + ppl - 1) / ppl);
        return g;
    endfunction

endpackage

// File: rtl/rs_encode_stream_out_engine_parity_buf.sv
// Parity line store: byte-lane-masked write, combinational read, no reset on the array.
module rs_parity_buf #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (wbe[b]) begin
                mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = (32'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/rs_encode_stream_out_engine.sv
// RS encoder output stage: passes data lines through, then emits packed parity lines.
// Optional RS_ENC_OUT_SKID_EN registers the output through a 2-entry skid buffer.
module rs_encode_stream_out_engine
    import rs_encode_stream_out_engine_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int RS_K_BYTES = 128,
    parameter int RS_T_BYTES = 32,
    parameter int MAX_BLOCKS = 64,
    parameter int BLOCKS_W   = $clog2(MAX_BLOCKS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_val,
    input  logic [BLOCKS_W-1:0]     req_num_blocks,
    output logic                    req_rdy,
    input  logic                    enc_val,
    input  logic [DATA_W-1:0]       enc_line,
    input  logic [8*RS_T_BYTES-1:0] enc_parity,
    output logic                    enc_rdy,
    output logic                    out_val,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    input  logic                    out_rdy,
    output logic                    busy
);

    localparam int       DATA_BYTES    = DATA_W / 8;
    localparam rs_geom_t GEOM          = rs_geom(DATA_W, RS_K_BYTES, RS_T_BYTES, MAX_BLOCKS);
    localparam int       LINES_PER_BLK = int'(GEOM.lines_per_blk);
    localparam int       PPL           = int'(GEOM.ppl);
    localparam int       PAR_DEPTH     = int'(GEOM.par_depth);
    localparam int       T_W           = 8 * RS_T_BYTES;
    localparam int       LINE_W        = (LINES_PER_BLK > 1) ? $clog2(LINES_PER_BLK) : 1;
    localparam int       SLOT_W        = (PPL > 1) ? $clog2(PPL) : 1;
    localparam int       ADDR_W        = (PAR_DEPTH > 1) ? $clog2(PAR_DEPTH) : 1;
    localparam int       PAR_W         = $clog2(PAR_DEPTH + 1);

    rs_out_state_e       state_q, state_d;
    logic [BLOCKS_W-1:0] nblk_q, nblk_d, blk_cnt_q, blk_cnt_d, nblk_sat;
    logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic [PAR_W-1:0]    par_rd_q, par_rd_d, par_last_q, par_last_d;
    logic [SLOT_W-1:0]   rem_q, rem_d;

    logic                src_val, src_last, src_rdy, par_we;
    logic [DATA_W-1:0]   src_data, par_rdata, par_masked;
    logic [ADDR_W-1:0]   par_waddr;
    logic [SLOT_W-1:0]   par_wslot;
    logic [DATA_BYTES-1:0] par_wbe;

    assign par_waddr = ADDR_W'(int'(blk_cnt_q) / PPL);
    assign par_wslot = SLOT_W'(int'(blk_cnt_q) % PPL);

    // Each codeword's parity lands in its own slot; stale slots beyond nblk are zeroed on read.
    for (genvar gi = 0; gi < PPL; gi++) begin : g_slot
        assign par_wbe[gi*RS_T_BYTES +: RS_T_BYTES] =
            {RS_T_BYTES{par_we && (par_wslot == SLOT_W'(gi))}};
        assign par_masked[gi*T_W +: T_W] =
            ((par_rd_q == par_last_q) && (rem_q != '0) && (SLOT_W'(gi) >= rem_q))
                ? '0 : par_rdata[gi*T_W +: T_W];
    end

    rs_parity_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (PAR_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_par_buf (
        .clk   (clk),
        .waddr (par_waddr),
        .wbe   (par_wbe),
        .wdata ({PPL{enc_parity}}),
        .raddr (ADDR_W'(par_rd_q)),
        .rdata (par_rdata)
    );

    always_comb begin
        state_d    = state_q;
        nblk_d     = nblk_q;
        blk_cnt_d  = blk_cnt_q;
        line_cnt_d = line_cnt_q;
        par_rd_d   = par_rd_q;
        par_last_d = par_last_q;
        rem_d      = rem_q;
        req_rdy    = 1'b0;
        enc_rdy    = 1'b0;
        src_val    = 1'b0;
        src_last   = 1'b0;
        src_data   = '0;
        par_we     = 1'b0;
        nblk_sat   = (req_num_blocks > BLOCKS_W'(MAX_BLOCKS)) ? BLOCKS_W'(MAX_BLOCKS)
                                                              : req_num_blocks;
        unique case (state_q)
            ST_IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    nblk_d     = nblk_sat;
                    line_cnt_d = '0;
                    blk_cnt_d  = '0;
                    par_rd_d   = '0;
                    par_last_d = PAR_W'((int'(nblk_sat) + PPL - 1) / PPL - 1);
                    rem_d      = SLOT_W'(int'(nblk_sat) % PPL);
                    if (nblk_sat != '0) state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                src_val  = enc_val;
                src_data = enc_line;
                enc_rdy  = src_rdy;
                if (enc_val && src_rdy) begin
                    if (line_cnt_q == LINE_W'(LINES_PER_BLK - 1)) begin
                        par_we     = 1'b1;
                        line_cnt_d = '0;
                        blk_cnt_d  = blk_cnt_q + BLOCKS_W'(1);
                        if (blk_cnt_q == nblk_q - BLOCKS_W'(1)) state_d = ST_PARITY;
                    end else begin
                        line_cnt_d = line_cnt_q + LINE_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                src_val  = 1'b1;
                src_data = par_masked;
                src_last = (par_rd_q == par_last_q);
                if (src_rdy) begin
                    par_rd_d = par_rd_q + PAR_W'(1);
                    if (src_last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            nblk_q     <= '0;
            blk_cnt_q  <= '0;
            line_cnt_q <= '0;
            par_rd_q   <= '0;
            par_last_q <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            nblk_q     <= nblk_d;
            blk_cnt_q  <= blk_cnt_d;
            line_cnt_q <= line_cnt_d;
            par_rd_q   <= par_rd_d;
            par_last_q <= par_last_d;
            rem_q      <= rem_d;
        end
    end

`ifdef RS_ENC_OUT_SKID_EN
    // Upstream advance looks only at skid occupancy, so out_rdy never reaches enc_rdy.
    logic [1:0]      skid_cnt_q;
    logic            skid_wr_q, skid_rd_q, skid_push, skid_pop;
    logic [DATA_W:0] skid_mem [2];

    assign src_rdy   = (skid_cnt_q != 2'd2);
    assign skid_push = src_val && src_rdy;
    assign out_val   = (skid_cnt_q != 2'd0);
    assign skid_pop  = out_val && out_rdy;
    assign {out_last, out_data} = out_val ? skid_mem[skid_rd_q] : '0;
    assign busy      = (state_q != ST_IDLE) || out_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_cnt_q <= 2'd0;
            skid_wr_q  <= 1'b0;
            skid_rd_q  <= 1'b0;
        end else begin
            skid_cnt_q <= skid_cnt_q + {1'b0, skid_push} - {1'b0, skid_pop};
            if (skid_push) skid_wr_q <= ~skid_wr_q;
            if (skid_pop)  skid_rd_q <= ~skid_rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (skid_push) skid_mem[skid_wr_q] <= {src_last, src_data};
    end
`else
    assign src_rdy  = out_rdy;
    assign out_val  = src_val;
    assign out_data = src_data;
    assign out_last = src_last;
    assign busy     = (state_q != ST_IDLE);
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        assert (RS_K_BYTES % DATA_BYTES == 0);
        assert (DATA_BYTES % RS_T_BYTES == 0);
    end
`endif

endmodule

// File: tb/tb_rs_encode_stream_out_engine.sv
// Randomized bench for rs_encode_stream_out_engine against a queue-based beat model.
// RS_T_BYTES=4 gives eight parity slots per 256-bit line, so packing and masking are exercised.
module tb_rs_encode_stream_out_engine;

    localparam int DATA_W     = 256;
    localparam int RS_K_BYTES = 128;
    localparam int RS_T_BYTES = 4;
    localparam int MAX_BLOCKS = 64;
    localparam int BLOCKS_W   = $clog2(MAX_BLOCKS + 1);
    localparam int LPB        = RS_K_BYTES / (DATA_W / 8);
    localparam int PPL        = (DATA_W / 8) / RS_T_BYTES;
    localparam int T_W        = 8 * RS_T_BYTES;
`ifdef RS_ENC_OUT_SKID_EN
    localparam int FIRST_LAT  = 2;
`else
    localparam int FIRST_LAT  = 1;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                last;
    } beat_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req_val;
    logic [BLOCKS_W-1:0] req_num_blocks;
    logic                req_rdy;
    logic                enc_val;
    logic [DATA_W-1:0]   enc_line;
    logic [T_W-1:0]      enc_parity;
    logic                enc_rdy;
    logic                out_val;
    logic [DATA_W-1:0]   out_data;
    logic                out_last;
    logic                out_rdy;
    logic                busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rs_encode_stream_out_engine #(
        .DATA_W     (DATA_W),
        .RS_K_BYTES (RS_K_BYTES),
        .RS_T_BYTES (RS_T_BYTES),
        .MAX_BLOCKS (MAX_BLOCKS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_val        (req_val),
        .req_num_blocks (req_num_blocks),
        .req_rdy        (req_rdy),
        .enc_val        (enc_val),
        .enc_line       (enc_line),
        .enc_parity     (enc_parity),
        .enc_rdy        (enc_rdy),
        .out_val        (out_val),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_rdy        (out_rdy),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_line();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_rdy"},  req_rdy,  1);
        chk({tag, "_enc_rdy"},  enc_rdy,  0);
        chk({tag, "_out_val"},  out_val,  0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_busy"},     busy,     0);
    endtask

    // One request: model builds the expected beat list, then a cycle loop drives and scores.
    task automatic run_req(input int n, input bit stall, input bit abort);
        int                nb;
        int                np;
        int                nlines;
        int                total;
        int                li;
        int                got;
        int                c;
        int                first;
        bit                acc;
        bit                done;
        bit                hold;
        logic [DATA_W-1:0] held;
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] lines[$];
        logic [T_W-1:0]    pars[$];
        beat_t             exp_q[$];
        beat_t             b;

        nb = (n > MAX_BLOCKS) ? MAX_BLOCKS : n;
        for (int i = 0; i < nb * LPB; i++) begin
            lines.push_back(rand_line());
            b.data = lines[i];
            b.last = 1'b0;
            exp_q.push_back(b);
        end
        for (int i = 0; i < nb; i++) pars.push_back(T_W'($urandom));
        np = (nb + PPL - 1) / PPL;
        for (int p = 0; p < np; p++) begin
            w = '0;
            for (int s = 0; s < PPL; s++) begin
                if (p * PPL + s < nb) w[s*T_W +: T_W] = pars[p*PPL + s];
            end
            b.data = w;
            b.last = (p == np - 1);
            exp_q.push_back(b);
        end
        nlines = lines.size();
        total  = exp_q.size();

        @(negedge clk);
        req_val        = 1'b1;
        req_num_blocks = BLOCKS_W'(n);
        enc_val        = 1'b0;
        out_rdy        = 1'b1;
        #4;
        chk($sformatf("n%0d_req_rdy", n), req_rdy, 1);
        @(posedge clk);

        if (nb == 0) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                req_val = 1'b0;
                #4;
                chk("zero_busy", busy, 0);
                chk("zero_out_val", out_val, 0);
                @(posedge clk);
            end
            $display("req n=%0d: no beats expected", n);
            return;
        end

        li = 0; got = 0; c = 0; first = -1;
        acc = 0; done = 0; hold = 0; held = '0;
        while (!done && c < 3000) begin
            @(negedge clk);
            c++;
            req_val = 1'b0;
            if (acc) begin
                enc_val = 1'b0;
                acc = 0;
            end
            if (li < nlines) begin
                if (!enc_val) enc_val = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                enc_line   = lines[li];
                enc_parity = ((li % LPB) == LPB - 1) ? pars[li / LPB] : T_W'($urandom);
            end else begin
                enc_val    = 1'b0;
                enc_parity = T_W'($urandom);
            end
            out_rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            #4;
            if (out_val && first < 0) first = c;
            if (hold) begin
                chk("stall_val", out_val, 1);
                chk("stall_data", out_data, held);
            end
            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", got + 1, total);
                    done = 1;
                end else begin
                    b = exp_q.pop_front();
                    chk($sformatf("n%0d_beat%0d_data", n, got), out_data, b.data);
                    chk($sformatf("n%0d_beat%0d_last", n, got), out_last, b.last);
                    if (out_last) done = 1;
                end
                got++;
                hold = 0;
            end else begin
                hold = out_val;
                held = out_data;
            end
            if (enc_val && enc_rdy) begin
                li++;
                acc = 1;
            end
            if (abort && got == nlines + 1) done = 1;
            @(posedge clk);
        end

        if (abort) begin
            $display("req n=%0d: abandoned after %0d beats", n, got);
            return;
        end
        chk($sformatf("n%0d_done", n), done, 1);
        chk($sformatf("n%0d_leftover", n), exp_q.size(), 0);
        chk($sformatf("n%0d_lines_taken", n), li, nlines);
        if (!stall) chk($sformatf("n%0d_first_lat", n), first, FIRST_LAT);
        @(negedge clk);
        enc_val = 1'b0;
        out_rdy = 1'b1;
        #4;
        chk($sformatf("n%0d_busy_after", n), busy, 0);
        @(posedge clk);
        $display("req n=%0d stall=%0d: %0d beats in %0d cycles, first beat at cycle %0d",
                 n, stall, got, c, first);
    endtask

    initial begin
        rst_n          = 1'b0;
        req_val        = 1'b0;
        req_num_blocks = '0;
        enc_val        = 1'b0;
        enc_line       = '0;
        enc_parity     = '0;
        out_rdy        = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(1, 0, 0);
        run_req(9, 0, 0);
        run_req(0, 0, 0);
        run_req(1, 0, 0);
        run_req(64, 0, 0);
        run_req(65, 0, 0);
        run_req(127, 1, 0);
        run_req(16, 1, 0);
        run_req(16, 1, 0);
        for (int i = 0; i < 3; i++) run_req($urandom_range(1, 20), 1, 0);

        run_req(9, 0, 1);
        @(negedge clk);
        enc_val = 1'b0;
        out_rdy = 1'b0;
        #1;
        chk("pre_rst_out_val", out_val, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_req(1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
